// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: parametrised, pipelined carry-select adder/subtractor
// with valid/ready handshakes on both sides and a global-stall pipeline.
//
// Parameters
//   WIDTH  operand width (multiple of BLOCK)
//   BLOCK  bits per carry-select block
//   STAGES pipeline register stages, 1..WIDTH/BLOCK, dividing WIDTH/BLOCK
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (in_ready is combinational)
//   A, B, cin, sub   operands; sub=1 computes A-B and ignores cin
//   out_valid/ready  result handshake
//   SUM              {carry_out, result}
//   ovf              two's-complement signed overflow of result
module pipelined_csa_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   SUM,
    output logic             ovf
);

    localparam int unsigned NB  = WIDTH / BLOCK;
    localparam int unsigned BPS = NB / STAGES;   // blocks resolved per stage
    localparam int unsigned SW  = BPS * BLOCK;   // result bits resolved per stage

    logic             adv;
    logic [WIDTH-1:0] bx_in;
    logic             c0_in;

    // Global stall: everything moves unless a result is waiting unconsumed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction as A + ~B + 1.
    assign bx_in = sub ? ~B : B;
    assign c0_in = sub | cin;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        // Operand bits still to be resolved, starting at bit s*SW.
        localparam int unsigned SRC_W = WIDTH - s * SW;

        logic [SRC_W-1:0]      a_src;
        logic [SRC_W-1:0]      bx_src;
        logic                  cy_src;
        logic                  vld_src;
        logic                  sa_src;
        logic                  sb_src;
        logic [SW-1:0]         blk_sum;
        logic [(s+1)*SW-1:0]   res_d;

        logic                  vld_q;
        logic                  cy_q;
        logic                  sa_q;
        logic                  sb_q;
        logic [(s+1)*SW-1:0]   res_q;

        // Stage source: the ports for stage 0, the previous register otherwise.
        if (s == 0) begin : g_src
            assign a_src   = A;
            assign bx_src  = bx_in;
            assign cy_src  = c0_in;
            assign vld_src = in_valid;
            assign sa_src  = A[WIDTH-1];
            assign sb_src  = bx_in[WIDTH-1];
            assign res_d   = blk_sum;
        end else begin : g_src
            assign a_src   = g_stg[s-1].g_up.a_q;
            assign bx_src  = g_stg[s-1].g_up.bx_q;
            assign cy_src  = g_stg[s-1].cy_q;
            assign vld_src = g_stg[s-1].vld_q;
            assign sa_src  = g_stg[s-1].sa_q;
            assign sb_src  = g_stg[s-1].sb_q;
            assign res_d   = {blk_sum, g_stg[s-1].res_q};
        end

        // Carry-select blocks: both candidate sums precomputed, carry picks one.
        for (genvar k = 0; k < BPS; k++) begin : g_blk
            logic           cy_in;
            logic           cout;
            logic [BLOCK:0] sum0;
            logic [BLOCK:0] sum1;

            if (k == 0) begin : g_cin
                assign cy_in = cy_src;
            end else begin : g_cin
                assign cy_in = g_blk[k-1].cout;
            end

            assign sum0 = {1'b0, a_src[k*BLOCK +: BLOCK]} + {1'b0, bx_src[k*BLOCK +: BLOCK]};
            assign sum1 = {1'b0, a_src[k*BLOCK +: BLOCK]} + {1'b0, bx_src[k*BLOCK +: BLOCK]}
                        + {{BLOCK{1'b0}}, 1'b1};
            assign {cout, blk_sum[k*BLOCK +: BLOCK]} = cy_in ? sum1 : sum0;
        end

        // Stage register: control, resolved low bits, carry and sign bits.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sa_q  <= 1'b0;
                sb_q  <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                vld_q <= vld_src;
                cy_q  <= g_blk[BPS-1].cout;
                sa_q  <= sa_src;
                sb_q  <= sb_src;
                res_q <= res_d;
            end
        end

        // Unresolved operand bits carried forward to later stages.
        if (s < STAGES - 1) begin : g_up
            logic [SRC_W-SW-1:0] a_q;
            logic [SRC_W-SW-1:0] bx_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (adv) begin
                    a_q  <= a_src[SRC_W-1:SW];
                    bx_q <= bx_src[SRC_W-1:SW];
                end
            end
        end
    end

    // Outputs come straight from the last stage register.
    assign out_valid = g_stg[STAGES-1].vld_q;
    assign SUM       = {g_stg[STAGES-1].cy_q, g_stg[STAGES-1].res_q};
    assign ovf       = (g_stg[STAGES-1].sa_q == g_stg[STAGES-1].sb_q)
                     && (g_stg[STAGES-1].res_q[WIDTH-1] != g_stg[STAGES-1].sa_q);

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Testbench for pipelined_csa_adder: four parameterisations driven from one
// shared stimulus stream, each scoreboarded against an arithmetic reference.
module tb_pipelined_csa_adder;

    typedef struct packed {
        logic [64:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic        cin;
    logic        sub;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        ov0, ov1, ov2, ov3;
    logic        of0, of1, of2, of3;
    logic [32:0] sum0;
    logic [16:0] sum1;
    logic [8:0]  sum2;
    logic [64:0] sum3;

    logic        irdy [4];
    logic        ovld [4];
    logic        oovf [4];
    logic [64:0] osum [4];

    exp_t        sb_q [4][$];
    exp_t        bp_exp [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipelined_csa_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .A(a_bus[31:0]), .B(b_bus[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .SUM(sum0), .ovf(of0));

    pipelined_csa_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .A(a_bus[15:0]), .B(b_bus[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .SUM(sum1), .ovf(of1));

    pipelined_csa_adder #(.WIDTH(8), .BLOCK(8), .STAGES(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .A(a_bus[7:0]), .B(b_bus[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .SUM(sum2), .ovf(of2));

    pipelined_csa_adder #(.WIDTH(64), .BLOCK(8), .STAGES(2)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .A(a_bus), .B(b_bus), .cin(cin), .sub(sub),
        .out_valid(ov3), .out_ready(out_ready), .SUM(sum3), .ovf(of3));

    assign irdy[0] = rdy0;  assign irdy[1] = rdy1;  assign irdy[2] = rdy2;  assign irdy[3] = rdy3;
    assign ovld[0] = ov0;   assign ovld[1] = ov1;   assign ovld[2] = ov2;   assign ovld[3] = ov3;
    assign oovf[0] = of0;   assign oovf[1] = of1;   assign oovf[2] = of2;   assign oovf[3] = of3;
    assign osum[0] = 65'(sum0);
    assign osum[1] = 65'(sum1);
    assign osum[2] = 65'(sum2);
    assign osum[3] = sum3;

    function automatic int unsigned w_of(input int i);
        case (i)
            0:       return 32;
            1:       return 16;
            2:       return 8;
            default: return 64;
        endcase
    endfunction

    // Reference: unsigned sum/difference plus a signed range check for ovf.
    function automatic exp_t ref_model(input int unsigned w, input logic [63:0] a_in,
                                       input logic [63:0] b_in, input logic sub_in,
                                       input logic cin_in);
        logic [64:0]        mask, a, b, tmp, res;
        logic               cout;
        logic signed [67:0] sa, sb, tot, lim;
        exp_t               r;
        mask = (65'd1 << w) - 65'd1;
        a    = {1'b0, a_in} & mask;
        b    = {1'b0, b_in} & mask;
        sa   = 68'(a);
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        sb   = 68'(b);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        if (sub_in) begin
            tot  = sa - sb;
            res  = (a - b) & mask;
            cout = (a >= b);
        end else begin
            tot  = sa + sb;
            if (cin_in) tot = tot + 68'sd1;
            tmp  = a + b + 65'(cin_in);
            cout = tmp[w];
            res  = tmp & mask;
        end
        lim     = 68'sd1 <<< (w - 1);
        r.ovf   = (tot >= lim) || (tot < -lim);
        r.sum   = res;
        r.sum[w] = cout;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [64:0] exp_sum, input logic exp_ovf);
        chk({tag, "_valid"}, 65'(ovld[0]), 65'd1);
        chk({tag, "_sum"},   osum[0], exp_sum);
        chk({tag, "_ovf"},   65'(oovf[0]), 65'(exp_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic c);
        in_valid = v;
        a_bus    = a;
        b_bus    = b;
        sub      = s;
        cin      = c;
    endtask

    // Scoreboard: sampled mid-cycle, on what will transfer at the next edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 4; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ovld[i] && out_ready) begin
                    n_cmp++;
                    assert (sb_q[i].size() != 0) else begin
                        n_bad++;
                        $error("FAIL sb%0d_unexpected: got %h want no beat", i, osum[i]);
                    end
                    if (sb_q[i].size() != 0) begin
                        e = sb_q[i].pop_front();
                        chk($sformatf("sb%0d_sum", i), osum[i], e.sum);
                        chk($sformatf("sb%0d_ovf", i), 65'(oovf[i]), 65'(e.ovf));
                    end
                end
                if (in_valid && irdy[i])
                    sb_q[i].push_back(ref_model(w_of(i), a_bus, b_bus, sub, cin));
            end
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        step();

        // Reset state.
        chk("rst_valid", 65'(ovld[0]), 65'd0);
        chk("rst_sum", osum[0], 65'd0);
        chk("rst_ovf", 65'(oovf[0]), 65'd0);
        chk("rst_in_ready", 65'(irdy[0]), 65'd1);
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", 65'(irdy[0]), 65'd1);

        // Back-to-back adds.
        drive(1'b1, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
        step();
        chk("latency_not_early", 65'(ovld[0]), 65'd0);
        drive(1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        chk_out("add_ovf", 65'h0_8000_0000, 1'b1);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk_out("add_carry", 65'h1_FFFF_FFFE, 1'b0);

        // Subtract.
        drive(1'b1, 64'h5, 64'h7, 1'b1, 1'b0);
        step();
        drive(1'b1, 64'h8000_0000, 64'h1, 1'b1, 1'b0);
        step();
        chk_out("sub_borrow", 65'h0_FFFF_FFFE, 1'b0);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk_out("sub_ovf", 65'h1_7FFF_FFFF, 1'b1);

        // Carry-in rippling through every block; cin ignored in subtract.
        drive(1'b1, 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1);
        step();
        drive(1'b1, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b0);
        step();
        chk_out("cin_chain", 65'h1_0000_0000, 1'b0);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk_out("sub_equal", 65'h1_0000_0000, 1'b0);
        step();
        chk("idle_after_burst", 65'(ovld[0]), 65'd0);

        // Backpressure: three beats, then a 5-cycle stall.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            bp_exp[j] = ref_model(32, a_bus, b_bus, sub, cin);
            step();
            if (j == 1) chk_out("bp_b1", bp_exp[0].sum, bp_exp[0].ovf);
        end
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            #1;
            chk("bp_in_ready", 65'(irdy[0]), 65'd0);
            chk_out("bp_hold", bp_exp[1].sum, bp_exp[1].ovf);
            step();
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk_out("bp_b2", bp_exp[1].sum, bp_exp[1].ovf);
        step();
        chk_out("bp_b3", bp_exp[2].sum, bp_exp[2].ovf);
        step();
        chk("bp_empty", 65'(ovld[0]), 65'd0);

        // Reset in the middle of traffic.
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        step();
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        step();
        chk("pre_rst_valid", 65'(ovld[0]), 65'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 65'(ovld[0]), 65'd0);
        chk("mid_rst_sum", osum[0], 65'd0);
        chk("mid_rst_ovf", 65'(oovf[0]), 65'd0);
        chk("mid_rst_valid_u3", 65'(ovld[3]), 65'd0);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 65'(irdy[0]), 65'd1);

        // Restart latency per parameterisation: 0x10 + 0x20 + 1.
        drive(1'b1, 64'h10, 64'h20, 1'b0, 1'b1);
        step();
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("lat1_u2_valid", 65'(ovld[2]), 65'd1);
        chk("lat1_u2_sum", osum[2], 65'h31);
        chk("lat1_u0_valid", 65'(ovld[0]), 65'd0);
        step();
        chk_out("lat2_u0", 65'h31, 1'b0);
        chk("lat2_u3_sum", osum[3], 65'h31);
        chk("lat2_u1_valid", 65'(ovld[1]), 65'd0);
        step();
        chk("lat3_u1_valid", 65'(ovld[1]), 65'd0);
        step();
        chk("lat4_u1_valid", 65'(ovld[1]), 65'd1);
        chk("lat4_u1_sum", osum[1], 65'h31);
        step();

        // Random traffic with random ready patterns.
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       ra = '1;
                1:       rb = '0;
                2:       rb = ~ra;
                default: ;
            endcase
            drive($urandom_range(0, 9) < 7, ra, rb, 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain and confirm nothing was lost.
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain_q%0d", i), 65'(sb_q[i].size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
